// File: rtl/audio_pkg.sv
// Shared types and constants for the I2S DAC transmit path.
// Sample pairs travel as one packed struct: left in the upper half, right in the lower half.
package audio_pkg;

  localparam int SMPL_W     = 16;
  localparam int FRAME_BITS = 2 * SMPL_W;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

  localparam logic [BIT_CNT_W-1:0] LR_HI_FIRST = BIT_CNT_W'(15);
  localparam logic [BIT_CNT_W-1:0] LR_HI_LAST  = BIT_CNT_W'(30);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT    = BIT_CNT_W'(FRAME_BITS - 1);

  typedef struct packed {
    logic signed [SMPL_W-1:0] lft;
    logic signed [SMPL_W-1:0] rht;
  } stereo_smpl_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tx_state_t;

  // Word select is high one slot early so each MSB follows an LRCLK edge by one SCLK.
  function automatic logic lr_sel(input logic [BIT_CNT_W-1:0] bit_idx);
    return (bit_idx >= LR_HI_FIRST) && (bit_idx <= LR_HI_LAST);
  endfunction

endpackage

// File: rtl/i2s_dac_tx_if.sv
// Sample-pair valid/ready handshake between the audio datapath and the I2S transmitter.
// The datapath is the master; the transmitter answers with smpl_rdy while its holding register is empty.
interface i2s_dac_tx_if;
  import audio_pkg::*;

  logic signed [SMPL_W-1:0] lft_in;
  logic signed [SMPL_W-1:0] rht_in;
  logic                     smpl_vld;
  logic                     smpl_rdy;

  modport master (output lft_in, output rht_in, output smpl_vld, input  smpl_rdy);
  modport slave  (input  lft_in, input  rht_in, input  smpl_vld, output smpl_rdy);
endinterface

// File: rtl/sclk_gen.sv
// SCLK divider: toggles SCLK every SCLK_HALF clks and flags the clk on which SCLK rises or falls.
// Strobes are combinational and coincide with the edge that toggles SCLK; i_clr parks SCLK low.
module sclk_gen #(
  parameter int SCLK_HALF = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_sclk,
  output logic o_fall_evt,
  output logic o_rise_evt
);

  localparam int DIV_W = $clog2(SCLK_HALF);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_sclk;
  logic             w_wrap;

  assign w_wrap = !i_clr && (r_div_cnt == DIV_W'(SCLK_HALF - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
    end else if (i_clr) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
    end else begin
      r_div_cnt <= w_wrap ? '0 : r_div_cnt + DIV_W'(1);
      if (w_wrap) r_sclk <= ~r_sclk;
    end
  end

  assign o_sclk     = r_sclk;
  assign o_fall_evt = w_wrap & r_sclk;
  assign o_rise_evt = w_wrap & ~r_sclk;

endmodule

// File: rtl/i2s_dac_tx.sv
// Philips I2S transmitter: one holding register in front of a 32-bit frame shifter, MSB first.
// First MSB 1 clk after acceptance from IDLE; in RUN a pair goes out next frame; smpl_rdy low while hold is full.
module i2s_dac_tx
  import audio_pkg::*;
#(
  parameter int SCLK_HALF = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  i2s_dac_tx_if.slave      smpl,
  output logic             SCLK,
  output logic             LRCLK,
  output logic             SDout,
  output logic             underrun
);

  tx_state_t              r_state;
  tx_state_t              w_state_nxt;
  stereo_smpl_t           r_hold;
  logic                   r_hold_full;
  logic                   r_smpl_rdy;
  logic [FRAME_BITS-1:0]  r_frame_sr;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic                   r_sdout;
  logic                   r_lrclk;
  logic                   r_underrun;

  logic                   w_sclk;
  logic                   w_fall_evt;
  logic                   w_rise_evt;
  logic                   w_accept;
  logic                   w_start;
  logic                   w_load;
  logic                   w_stop;
  logic                   w_urun;
  logic [FRAME_BITS-1:0]  w_frame_nxt;
  logic [BIT_CNT_W-1:0]   w_bit_nxt;

  sclk_gen #(.SCLK_HALF(SCLK_HALF)) u_sclk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (r_state == IDLE),
    .o_sclk     (w_sclk),
    .o_fall_evt (w_fall_evt),
    .o_rise_evt (w_rise_evt)
  );

  assign w_accept = smpl.smpl_vld && r_smpl_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_load      = 1'b0;
    w_stop      = 1'b0;
    w_urun      = 1'b0;
    case (r_state)
      IDLE: begin
        if (en && r_hold_full) begin
          w_state_nxt = RUN;
          w_start     = 1'b1;
          w_load      = 1'b1;
        end
      end
      RUN: begin
        if (w_fall_evt && (r_bit_cnt == LAST_BIT)) begin
          if (!en) begin
            w_state_nxt = IDLE;
            w_stop      = 1'b1;
          end else if (r_hold_full) begin
            w_load = 1'b1;
          end else begin
            w_urun = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Accept and load are exclusive: accept needs hold empty, load needs it full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_smpl_rdy  <= 1'b1;
    end else if (w_accept) begin
      r_hold      <= '{lft: smpl.lft_in, rht: smpl.rht_in};
      r_hold_full <= 1'b1;
      r_smpl_rdy  <= 1'b0;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
      r_smpl_rdy  <= 1'b1;
    end
  end

  assign w_frame_nxt = w_load ? FRAME_BITS'(r_hold) : r_frame_sr;
  assign w_bit_nxt   = r_bit_cnt + BIT_CNT_W'(1);

  // SDout/LRCLK move only on the SCLK fall so they are settled at every rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_sr <= '0;
      r_bit_cnt  <= '0;
      r_sdout    <= 1'b0;
      r_lrclk    <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_urun;
      if (w_start) begin
        r_frame_sr <= FRAME_BITS'(r_hold);
        r_bit_cnt  <= '0;
        r_sdout    <= r_hold.lft[SMPL_W-1];
        r_lrclk    <= 1'b0;
      end else if ((r_state == IDLE) || w_stop) begin
        r_bit_cnt  <= '0;
        r_sdout    <= 1'b0;
        r_lrclk    <= 1'b0;
      end else if (w_fall_evt) begin
        r_frame_sr <= w_frame_nxt;
        r_bit_cnt  <= w_bit_nxt;
        r_sdout    <= w_frame_nxt[~w_bit_nxt];
        r_lrclk    <= lr_sel(w_bit_nxt);
      end
    end
  end

  a_stable_on_rise: assert property (@(posedge clk) disable iff (!rst_n)
    w_rise_evt |=> ($stable(r_sdout) && $stable(r_lrclk)));

  assign smpl.smpl_rdy = r_smpl_rdy;
  assign SCLK          = w_sclk;
  assign LRCLK         = r_lrclk;
  assign SDout         = r_sdout;
  assign underrun      = r_underrun;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx at SCLK_HALF=2 (one serial bit every 4 clks).
// Each serial bit is captured at the SCLK rise together with LRCLK and compared against hand-built frames.
module tb_i2s_dac_tx;

  localparam int          HALF     = 2;
  localparam int          BIT_CLKS = 2 * HALF;
  localparam logic [31:0] LR_EXP   = 32'h0001_FFFE;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;
  logic sclk, lrclk, sdout, underrun;

  i2s_dac_tx_if smpl_if ();

  i2s_dac_tx #(.SCLK_HALF(HALF)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .smpl     (smpl_if),
    .SCLK     (sclk),
    .LRCLK    (lrclk),
    .SDout    (sdout),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int         tests     = 0;
  int         fails     = 0;
  int         cyc       = 0;
  logic [1:0] bits_q[$];
  logic       prev_sclk = 1'b0;
  bit         chk_gap   = 1'b0;
  int         last_rise = -1;
  int         gap_err   = 0;
  int         ur_cnt    = 0;

  task step();
    @(posedge clk);
    #1;
    cyc++;
    if (sclk === 1'b1 && prev_sclk === 1'b0) begin
      bits_q.push_back({lrclk, sdout});
      if (chk_gap && last_rise >= 0 && (cyc - last_rise) != BIT_CLKS) gap_err++;
      last_rise = cyc;
    end
    prev_sclk = sclk;
    if (underrun === 1'b1) ur_cnt++;
  endtask

  task automatic wait_bits(input int n, output bit ok);
    int t;
    ok = 1'b1;
    t  = 0;
    while (bits_q.size() < n && t < 600) begin
      step();
      t++;
    end
    if (bits_q.size() < n) begin
      tests++;
      fails++;
      ok = 1'b0;
      $display("FAIL wait_bits: got %0d bits, required %0d", bits_q.size(), n);
    end
  endtask

  task automatic get_frame(output logic [31:0] d, output logic [31:0] lr, output bit ok);
    logic [1:0] b;
    d  = '0;
    lr = '0;
    wait_bits(32, ok);
    if (ok) begin
      for (int k = 0; k < 32; k++) begin
        b          = bits_q.pop_front();
        d[31-k]    = b[0];
        lr[31-k]   = b[1];
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    en    = 1'b0;
    smpl_if.smpl_vld = 1'b0;
    smpl_if.lft_in   = '0;
    smpl_if.rht_in   = '0;
    repeat (3) step();
    tests++;
    if ({sclk, lrclk, sdout, underrun, smpl_if.smpl_rdy} !== 5'b00001) begin
      fails++;
      $display("FAIL reset_vals: got %b, required 00001", {sclk, lrclk, sdout, underrun, smpl_if.smpl_rdy});
    end
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if ({sclk, lrclk, sdout, underrun, smpl_if.smpl_rdy} !== 5'b00001) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL idle_outputs: %0d bad cycles, required 0", bad);
    end
  endtask

  task automatic test_single_frame();
    logic [31:0] d, lr;
    bit ok;
    bits_q.delete();
    smpl_if.lft_in   = 16'hA5C3;
    smpl_if.rht_in   = 16'h0F0F;
    smpl_if.smpl_vld = 1'b1;
    en = 1'b1;
    step();
    tests++;
    if ({smpl_if.smpl_rdy, sdout} !== 2'b00) begin
      fails++;
      $display("FAIL accept: rdy,sdout=%b, required 00", {smpl_if.smpl_rdy, sdout});
    end
    smpl_if.smpl_vld = 1'b0;
    step();
    tests++;
    if ({sclk, lrclk, sdout, smpl_if.smpl_rdy} !== 4'b0011) begin
      fails++;
      $display("FAIL start_msb: sclk,lrclk,sdout,rdy=%b, required 0011", {sclk, lrclk, sdout, smpl_if.smpl_rdy});
    end
    chk_gap   = 1'b1;
    last_rise = -1;
    gap_err   = 0;
    get_frame(d, lr, ok);
    if (ok) begin
      tests++;
      if (d !== 32'hA5C3_0F0F) begin
        fails++;
        $display("FAIL frame1_data: got %h, required A5C30F0F", d);
      end
      tests++;
      if (lr !== LR_EXP) begin
        fails++;
        $display("FAIL frame1_lrclk: got %h, required %h", lr, LR_EXP);
      end
    end
  endtask

  task automatic test_underrun();
    logic [31:0] d, lr;
    bit ok;
    int u0;
    u0 = ur_cnt;
    step();
    smpl_if.lft_in   = 16'h8000;
    smpl_if.rht_in   = 16'h7FFF;
    smpl_if.smpl_vld = 1'b1;
    step();
    tests++;
    if (underrun !== 1'b1) begin
      fails++;
      $display("FAIL underrun_pulse: got %b, required 1", underrun);
    end
    tests++;
    if ({smpl_if.smpl_rdy, sdout, lrclk} !== 3'b010) begin
      fails++;
      $display("FAIL underrun_boundary: rdy,sdout,lrclk=%b, required 010", {smpl_if.smpl_rdy, sdout, lrclk});
    end
    smpl_if.smpl_vld = 1'b0;
    repeat (3) step();
    tests++;
    if (ur_cnt - u0 != 1) begin
      fails++;
      $display("FAIL underrun_width: %0d cycles high, required 1", ur_cnt - u0);
    end
    get_frame(d, lr, ok);
    if (ok) begin
      tests++;
      if (d !== 32'hA5C3_0F0F || lr !== LR_EXP) begin
        fails++;
        $display("FAIL repeat_frame: got %h/%h, required A5C30F0F/%h", d, lr, LR_EXP);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, lr;
    bit ok;
    step();
    tests++;
    if (smpl_if.smpl_rdy !== 1'b0) begin
      fails++;
      $display("FAIL rdy_before_load: got %b, required 0", smpl_if.smpl_rdy);
    end
    step();
    tests++;
    if ({smpl_if.smpl_rdy, sdout, underrun} !== 3'b110) begin
      fails++;
      $display("FAIL load_clk: rdy,sdout,underrun=%b, required 110", {smpl_if.smpl_rdy, sdout, underrun});
    end
    smpl_if.lft_in   = 16'h0001;
    smpl_if.rht_in   = 16'hFFFF;
    smpl_if.smpl_vld = 1'b1;
    step();
    tests++;
    if (smpl_if.smpl_rdy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_accept: rdy=%b, required 0", smpl_if.smpl_rdy);
    end
    smpl_if.smpl_vld = 1'b0;
    get_frame(d, lr, ok);
    if (ok) begin
      tests++;
      if (d !== 32'h8000_7FFF || lr !== LR_EXP) begin
        fails++;
        $display("FAIL frame_8000: got %h/%h, required 80007FFF/%h", d, lr, LR_EXP);
      end
    end
  endtask

  task automatic test_en_drop();
    logic [31:0] d, lr;
    bit ok;
    int u0, bad;
    u0 = ur_cnt;
    step();
    step();
    tests++;
    if ({smpl_if.smpl_rdy, sdout} !== 2'b10) begin
      fails++;
      $display("FAIL load_0001: rdy,sdout=%b, required 10", {smpl_if.smpl_rdy, sdout});
    end
    smpl_if.lft_in   = 16'h1234;
    smpl_if.rht_in   = 16'h5678;
    smpl_if.smpl_vld = 1'b1;
    step();
    smpl_if.smpl_vld = 1'b0;
    wait_bits(8, ok);
    en = 1'b0;
    get_frame(d, lr, ok);
    if (ok) begin
      tests++;
      if (d !== 32'h0001_FFFF || lr !== LR_EXP) begin
        fails++;
        $display("FAIL frame_0001: got %h/%h, required 0001FFFF/%h", d, lr, LR_EXP);
      end
    end
    tests++;
    if (gap_err != 0) begin
      fails++;
      $display("FAIL sclk_gap: %0d irregular SCLK periods, required 0", gap_err);
    end
    chk_gap = 1'b0;
    step();
    step();
    tests++;
    if ({sclk, lrclk, sdout, underrun, smpl_if.smpl_rdy} !== 5'b00000) begin
      fails++;
      $display("FAIL stop_outputs: got %b, required 00000", {sclk, lrclk, sdout, underrun, smpl_if.smpl_rdy});
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if ({sclk, lrclk, sdout, smpl_if.smpl_rdy} !== 4'b0000) bad++;
    end
    tests++;
    if (bad != 0 || bits_q.size() != 0 || ur_cnt != u0) begin
      fails++;
      $display("FAIL idle_after_stop: bad=%0d bits=%0d underruns=%0d, required 0/0/0",
               bad, bits_q.size(), ur_cnt - u0);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0]  b;
    logic [20:0] d;
    bit ok;
    int bad;
    bits_q.delete();
    en = 1'b1;
    step();
    tests++;
    if ({sclk, sdout, smpl_if.smpl_rdy} !== 3'b001) begin
      fails++;
      $display("FAIL restart: sclk,sdout,rdy=%b, required 001", {sclk, sdout, smpl_if.smpl_rdy});
    end
    wait_bits(21, ok);
    if (ok) begin
      d = '0;
      for (int k = 0; k < 21; k++) begin
        b = bits_q.pop_front();
        d = {d[19:0], b[0]};
      end
      tests++;
      if (d !== 21'h0_2468A || lrclk !== 1'b1 || sclk !== 1'b1) begin
        fails++;
        $display("FAIL pre_reset: bits=%h lrclk=%b sclk=%b, required 2468A/1/1", d, lrclk, sclk);
      end
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({sclk, lrclk, sdout, underrun, smpl_if.smpl_rdy} !== 5'b00001) begin
      fails++;
      $display("FAIL async_reset: got %b, required 00001", {sclk, lrclk, sdout, underrun, smpl_if.smpl_rdy});
    end
    repeat (2) step();
    rst_n = 1'b1;
    bits_q.delete();
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if ({sclk, lrclk, sdout, smpl_if.smpl_rdy} !== 4'b0001) bad++;
    end
    tests++;
    if (bad != 0 || bits_q.size() != 0) begin
      fails++;
      $display("FAIL post_reset_idle: bad=%0d bits=%0d, required 0/0", bad, bits_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_underrun();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2s_dac_tx.md
Name: i2s_dac_tx

Overview:
- Transmits the processed stereo stream (the same lft/rht sample pair the LED level meter consumes) to the codec DAC as standard I2S, Philips format.
- Accepts 16-bit left/right pairs through a valid/ready handshake and double-buffers them in a holding register.
- Generates SCLK, LRCLK and SDout from the system clock.
- Sits between the audio datapath output and the codec pins.

Parameters:
- SCLK_HALF, 16: system clocks per SCLK half-period. 50 MHz gives 1.5625 MHz SCLK and a 48.83 kHz frame rate. Must be ≥2.
- SMPL_W, 16: bits per channel. The frame is 2*SMPL_W SCLK periods.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  transmit enable
- lft_in  in  16  left sample, two's complement
- rht_in  in  16  right sample, two's complement
- smpl_vld  in  1  sample pair valid
- smpl_rdy  out  1  holding register empty; accepts pair when vld&rdy
- SCLK  out  1  serial bit clock
- LRCLK  out  1  word select; 0 = left, 1 = right
- SDout  out  1  serial data, MSB first
- underrun  out  1  one-clk pulse, frame started with no new pair

Behaviour:
- Clock and reset: reset is rst_n, asynchronous, active-low; the clock is clk. All outputs are registered.
- Reset values: SCLK=0, LRCLK=0, SDout=0, smpl_rdy=1, underrun=0, state=IDLE. Counters, holding register, shift register and hold_full all clear to 0.
- Handshake: smpl_rdy = !hold_full. On vld&rdy at a clk edge, {lft_in,rht_in} latch into hold and hold_full sets. smpl_vld while rdy=0 is ignored; nothing is overwritten.
- SCLK divider: div_cnt counts 0..SCLK_HALF-1 and wraps. On wrap, SCLK toggles.
  - Wrap while SCLK=1 is a "fall event". On a fall event, bit_cnt (5 bits, 0..31) increments and wraps 31→0.
- Data mapping: during bit_cnt=k, SDout = frame_sr[31-k], where frame_sr = {L,R}. SDout and LRCLK update only on the fall event, so they are stable across every SCLK rising edge.
- LRCLK: 1 for bit_cnt 15..30, 0 for bit_cnt 31 and 0..14. This gives the I2S one-SCLK lead before each MSB.
- Frame load (fall event with bit_cnt 31→0):
  - If hold_full: frame_sr <= hold and hold_full clears.
  - Else: frame_sr keeps its previous word, the previous pair repeats, and underrun pulses for 1 clk.
  - If the load and vld&rdy land on the same clk, the frame uses the old contents (no bypass). The new pair enters hold; underrun applies if hold was empty.
- FSM IDLE:
  - SCLK=0, LRCLK=0, SDout=0; div_cnt and bit_cnt held at 0. The handshake still operates.
  - Transition to RUN when en=1 and hold_full=1.
  - On the transition clk: frame_sr <= hold, hold_full clears, bit_cnt=0, div_cnt=0, SDout=L[15], LRCLK=0.
  - The first frame lacks the bit-31 lead slot; this is accepted.
- FSM RUN:
  - en=0 mid-frame: the frame completes. At the next 31→0 fall event go to IDLE, with no load and no underrun. All outputs return to their IDLE values on that clk.
  - en=1 at the boundary: continue normally.
- Latency: a pair accepted in IDLE with en=1 drives its MSB on SDout 1 clk after acceptance. In RUN, a pair is transmitted in the next frame after acceptance.
- Reset mid-frame: outputs go to reset values immediately. Any pair in flight is discarded.

Decomposition:
- audio_pkg:
  - SMPL_W=16 and FRAME_BITS=32
  - typedef stereo_smpl_t = struct {lft, rht} of signed [15:0]
  - enum tx_state_t {IDLE, RUN}
  - constants LR_HI_FIRST=15, LR_HI_LAST=30
- One sub-module, sclk_gen: holds div_cnt and SCLK, and outputs fall_evt/rise_evt strobes. It has a synchronous clear for IDLE.
- The handshake, FSM and shift register stay in i2s_dac_tx.

Test Plan:
- Reset, then idle: smpl_rdy=1, SCLK=LRCLK=SDout=0 and underrun=0 for 100 clks with en=0.
- SCLK_HALF=2, en=1, one pair L=16'hA5C3, R=16'h0F0F:
  - SDout reads 1010010111000011 then 0000111100001111, one bit per SCLK (4 clks), sampled on SCLK rise.
  - LRCLK rises at bit_cnt 15 and falls at bit_cnt 31.
- Back-to-back pairs 16'h8000/16'h7FFF then 16'h0001/16'hFFFF:
  - smpl_rdy drops on accept and reasserts on the clk of the frame load.
  - Both frames are bit-exact with no gap in SCLK.
- No second pair supplied:
  - underrun pulses exactly 1 clk at the 31→0 boundary.
  - The A5C3/0F0F frame repeats.
  - A pair offered on that same clk is transmitted the following frame.
- Drop en at bit_cnt 7: the frame finishes all 32 bits, then SCLK, LRCLK and SDout are held 0. A held pair remains with smpl_rdy=0.
- Assert rst_n=0 at bit_cnt 20: all outputs reach reset values within the same clk. After release the block is in IDLE with smpl_rdy=1.
